digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

- Parametrised, multi-cycle successor to the combinational half adder.
- Adds or subtracts two `WIDTH`-bit operands `DIGIT` bits per clock, least-significant digit first, carrying between digits in a register.
- Reports carry-out and signed overflow, with a start/ready/done handshake.
- Used in area-constrained datapaths in the comb/seq examples, where a full-width adder is not wanted.

## Interface
Parameters:
- `WIDTH`, 16, operand and result width in bits; must be a multiple of `DIGIT`.
- `DIGIT`, 4, bits processed per cycle; 1 ≤ `DIGIT` ≤ `WIDTH`.
- `SUB_EN`, 1, when 0 the `sub` input is ignored and treated as 0.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1, rising-edge clock.
- `rst_n`, input, 1, asynchronous active-low reset.
- `start`, input, 1, request an operation; accepted only while `ready`=1.
- `sub`, input, 1, sampled with `start`: 0 = A+B, 1 = A−B.
- `a`, input, `WIDTH`, operand A; sampled with `start`.
- `b`, input, `WIDTH`, operand B; sampled with `start`.
- `ready`, output, 1, high in IDLE only.
- `busy`, output, 1, high in RUN only.
- `done`, output, 1, one-cycle pulse; results valid.
- `sum`, output, `WIDTH`, result.
- `carry_out`, output, 1, carry out of the MSB. In subtract mode it is 1 when there is no borrow.
- `overflow`, output, 1, two's-complement overflow.

## Operation
- `NDIG` = `WIDTH`/`DIGIT`.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when `start`=1 at a clock edge. On that edge:
  - `a` is latched.
  - `b` is latched, bit-inverted if the effective `sub`=1.
  - The carry register is set to the effective `sub`.
  - The digit counter is set to 0.
- In RUN, each edge:
  - Adds digit[counter] of A and B plus the carry register.
  - Writes the `DIGIT`-bit result into `sum` at that digit position.
  - Updates the carry register and increments the counter.
- RUN → DONE on the edge that processes digit `NDIG`−1. On that edge:
  - `carry_out` takes the final carry.
  - `overflow` takes (carry into bit `WIDTH`−1) XOR (carry out of bit `WIDTH`−1).
- DONE → IDLE unconditionally on the next edge.
- `done` = (state==DONE).
- `sum`, `carry_out` and `overflow` hold their values until the next accepted `start`. The start edge clears `carry_out` and `overflow`. `sum` is overwritten progressively.
- `start` in RUN or DONE is ignored; it is not queued.
- Operand inputs may change freely after the start edge.
- Arithmetic is modulo 2^`WIDTH`; there is no saturation.
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `sum`=0, `carry_out`=0, `overflow`=0, counter 0, carry register 0.
- Reset asserted mid-operation aborts immediately to the reset values. No `done` is issued for the aborted operation.

## Timing
- Start sampled at edge 0. Edges 1..`NDIG` process digits 0..`NDIG`−1.
- `done`=1 in the cycle following edge `NDIG`.
- `ready` returns after edge `NDIG`+1.
- Minimum issue interval: `NDIG`+2 cycles. Example: `WIDTH`=16, `DIGIT`=4 gives `done` 4 cycles after the start edge and a new start accepted every 6 cycles.
- For `NDIG`=1 (`DIGIT`=`WIDTH`), a single RUN cycle is followed by DONE.
- No combinational path from `start`, `a` or `b` to any output.
- All outputs are registered or decoded from state only.

## Structure
- Shared package `dsa_pkg` holds:
  - state enum `dsa_state_t` {IDLE, RUN, DONE};
  - a localparam function computing `NDIG`;
  - a counter-width helper (clog2 of `NDIG`, minimum 1).
- One sub-module, `fa_digit`:
  - combinational `DIGIT`-bit ripple adder built from half-adder pairs;
  - ports: `x`, `y`, `cin`, `s`, `cout`, `c_msb_in` (carry into its top bit, used for overflow).
- Top level holds the FSM, operand registers, digit counter and result registers.
- Elaboration-time check: `WIDTH` % `DIGIT` == 0.

## Test plan
All directed cases use `WIDTH`=16, `DIGIT`=4 unless stated.
- Add 0x00FF + 0x0001 → `sum`=0x0100, `carry_out`=0, `overflow`=0. `done` pulses exactly 4 cycles after the start edge, for 1 cycle. `ready` is back 1 cycle later.
- Add 0xFFFF + 0x0001 → `sum`=0x0000, `carry_out`=1, `overflow`=0.
- Add 0x7FFF + 0x0001 → `sum`=0x8000, `carry_out`=0, `overflow`=1.
- Subtract 0x0005 − 0x0007 → `sum`=0xFFFE, `carry_out`=0, `overflow`=0.
- Subtract 0x8000 − 0x0001 → `sum`=0x7FFF, `carry_out`=1, `overflow`=1.
- Start 0x1234 + 0x1111 while busy, then start 0xAAAA + 0x5555 during RUN:
  - the second start is ignored; single `done` with `sum`=0x2345;
  - afterwards, reset pulsed at RUN cycle 2 gives all outputs 0, `ready`=1, no `done`;
  - with `SUB_EN`=0, `sub`=1 still adds.
- Instance with `DIGIT`=16: 0xFFFF + 0xFFFF → `sum`=0xFFFE, `carry_out`=1, `done` 1 cycle after start.
- Randomised back-to-back operations are checked against a reference model.

Source files
------------

// File: rtl/dsa_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
//   dsa_state_t : FSM state encoding (IDLE, RUN, DONE)
//   ndig_f      : number of digits per operand (WIDTH / DIGIT)
//   cnt_w_f     : digit counter width, clog2(NDIG) with a floor of 1
package dsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsa_state_t;

    function automatic int unsigned ndig_f(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    function automatic int unsigned cnt_w_f(input int unsigned ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Start/ready/done handshake and operand/result bus of the digit-serial adder.
//   master : drives start, sub, a, b; observes ready, busy, done, sum, carry_out, overflow
//   slave  : the adder side of the same signals
interface digit_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  ready, busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output ready, busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/digit_serial_adder_fa_digit.sv
// Combinational DIGIT-bit ripple adder built from half-adder pairs.
//   x, y     : digit operands
//   cin      : carry in
//   s        : digit sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (for signed overflow)
module fa_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] h;
    logic [DIGIT-1:0] g;
    logic [DIGIT-1:0] p;

    assign c[0] = cin;

    // Each bit: first half adder on x/y, second on partial sum/carry
    for (genvar i = 0; i < int'(DIGIT); i++) begin : g_bit
        assign h[i]   = x[i] ^ y[i];
        assign g[i]   = x[i] & y[i];
        assign s[i]   = h[i] ^ c[i];
        assign p[i]   = h[i] & c[i];
        assign c[i+1] = g[i] | p[i];
    end

    assign cout     = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract of two WIDTH-bit operands, DIGIT bits per clock, LSD first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/sub/a/b in; ready/busy/done/sum/carry_out/overflow out (all registered)
module digit_serial_adder
    import dsa_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGIT  = 4,
    parameter int unsigned SUB_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    digit_serial_adder_if.slave  bus
);
    localparam int unsigned NDIG = ndig_f(WIDTH, DIGIT);
    localparam int unsigned CW   = cnt_w_f(NDIG);

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
        $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
    end

    dsa_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             co_q;
    logic             ov_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    int unsigned      base;
    logic [DIGIT-1:0] x_dig;
    logic [DIGIT-1:0] y_dig;
    logic [DIGIT-1:0] s_dig;
    logic             d_cout;
    logic             d_cmsb;
    logic             sub_eff;
    logic             last;

    // Digit slice selected by the counter
    assign base    = 32'(cnt) * DIGIT;
    assign x_dig   = a_q[base +: DIGIT];
    assign y_dig   = b_q[base +: DIGIT];
    assign sub_eff = (SUB_EN != 0) && bus.sub;
    assign last    = (cnt == CW'(NDIG - 1));

    fa_digit #(.DIGIT(DIGIT)) u_fa (
        .x        (x_dig),
        .y        (y_dig),
        .cin      (carry_q),
        .s        (s_dig),
        .cout     (d_cout),
        .c_msb_in (d_cmsb)
    );

    // FSM, operand/result registers and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtract as A + ~B + 1: invert B and seed the carry
                        a_q     <= bus.a;
                        b_q     <= sub_eff ? ~bus.b : bus.b;
                        carry_q <= sub_eff;
                        cnt     <= '0;
                        co_q    <= 1'b0;
                        ov_q    <= 1'b0;
                        state   <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[base +: DIGIT] <= s_dig;
                    carry_q              <= d_cout;
                    if (last) begin
                        cnt    <= '0;
                        co_q   <= d_cout;
                        ov_q   <= d_cmsb ^ d_cout;
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = co_q;
    assign bus.overflow  = ov_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: directed cases, handshake timing,
// reset abort, SUB_EN=0 and DIGIT=WIDTH instances, random back-to-back ops.
module tb_digit_serial_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        co;
        logic        ov;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    res_t sb[$];

    digit_serial_adder_if #(.WIDTH(16)) bus0 ();
    digit_serial_adder_if #(.WIDTH(16)) bus1 ();
    digit_serial_adder_if #(.WIDTH(16)) bus2 ();

    digit_serial_adder #(.WIDTH(16), .DIGIT(4),  .SUB_EN(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    digit_serial_adder #(.WIDTH(16), .DIGIT(4),  .SUB_EN(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    digit_serial_adder #(.WIDTH(16), .DIGIT(16), .SUB_EN(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Full-width reference: A + (sub ? ~B : B) + sub
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [15:0] bb;
        logic [16:0] r;
        res_t        o;
        bb   = sub ? ~b : b;
        r    = {1'b0, a} + {1'b0, bb} + 17'(sub);
        o.sum = r[15:0];
        o.co  = r[16];
        o.ov  = (a[15] == bb[15]) && (r[15] != a[15]);
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for ready, presents one op for one edge, pushes its expected result
    task automatic issue0(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int w = 0;
        while (!bus0.ready && w < 20) begin
            step();
            w++;
        end
        bus0.start = 1'b1;
        bus0.a     = a;
        bus0.b     = b;
        bus0.sub   = sub;
        sb.push_back(model(a, b, sub));
        step();
        bus0.start = 1'b0;
        bus0.a     = 16'($urandom);
        bus0.b     = 16'($urandom);
        bus0.sub   = 1'($urandom);
    endtask

    task automatic wait_done0(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!bus0.done && lat < 40);
    endtask

    task automatic test_reset();
        logic [20:0] got;
        step();
        got = {bus0.ready, bus0.busy, bus0.done, bus0.sum, bus0.carry_out, bus0.overflow};
        n_checks++;
        if (got !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0})
            $display("FAIL reset_state: got %h required %h", got, {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
        else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_arith();
        logic [15:0] ta [5] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [15:0] tb [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
        logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        res_t        te [5] = '{{16'h0100, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b0},
                                {16'h8000, 1'b0, 1'b1}, {16'hFFFE, 1'b0, 1'b0},
                                {16'h7FFF, 1'b1, 1'b1}};
        for (int i = 0; i < 5; i++) begin
            int   lat;
            res_t got;
            res_t exp_sb;
            issue0(ta[i], tb[i], ts[i]);
            wait_done0(lat);
            got    = {bus0.sum, bus0.carry_out, bus0.overflow};
            exp_sb = (sb.size() > 0) ? sb.pop_front() : '0;
            n_checks++;
            if (!bus0.done || got !== te[i])
                $display("FAIL arith_%0d: done %b result %h required %h", i, bus0.done, got, te[i]);
            else n_pass++;
            n_checks++;
            if (got !== exp_sb)
                $display("FAIL arith_sb_%0d: result %h required %h", i, got, exp_sb);
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if (lat !== 4) $display("FAIL done_latency: got %0d required 4", lat);
                else n_pass++;
                step();
                n_checks++;
                if ({bus0.done, bus0.ready} !== 2'b01)
                    $display("FAIL done_pulse_ready: done/ready %b required 01", {bus0.done, bus0.ready});
                else n_pass++;
            end
        end
    endtask

    task automatic test_hold_clear();
        int   lat;
        res_t got;
        res_t exp_sb;
        repeat (3) step();
        got = {bus0.sum, bus0.carry_out, bus0.overflow};
        n_checks++;
        if (got !== {16'h7FFF, 1'b1, 1'b1})
            $display("FAIL result_hold: got %h required %h", got, {16'h7FFF, 1'b1, 1'b1});
        else n_pass++;
        issue0(16'h0001, 16'h0001, 1'b0);
        n_checks++;
        if ({bus0.carry_out, bus0.overflow, bus0.busy, bus0.ready} !== 4'b0010)
            $display("FAIL start_clears_flags: co/ov/busy/ready %b required 0010",
                     {bus0.carry_out, bus0.overflow, bus0.busy, bus0.ready});
        else n_pass++;
        wait_done0(lat);
        got    = {bus0.sum, bus0.carry_out, bus0.overflow};
        exp_sb = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (!bus0.done || got !== exp_sb)
            $display("FAIL clear_then_add: done %b result %h required %h", bus0.done, got, exp_sb);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        int   lat;
        int   extra = 0;
        res_t got;
        res_t exp_sb;
        issue0(16'h1234, 16'h1111, 1'b0);
        step();
        bus0.start = 1'b1;
        bus0.a     = 16'hAAAA;
        bus0.b     = 16'h5555;
        bus0.sub   = 1'b0;
        step();
        bus0.start = 1'b0;
        wait_done0(lat);
        got    = {bus0.sum, bus0.carry_out, bus0.overflow};
        exp_sb = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (!bus0.done || got !== {16'h2345, 1'b0, 1'b0})
            $display("FAIL ignore_start_result: done %b result %h required %h",
                     bus0.done, got, {16'h2345, 1'b0, 1'b0});
        else n_pass++;
        n_checks++;
        if (got !== exp_sb) $display("FAIL ignore_start_sb: result %h required %h", got, exp_sb);
        else n_pass++;
        repeat (10) begin
            step();
            if (bus0.done) extra++;
        end
        n_checks++;
        if (extra !== 0 || bus0.ready !== 1'b1)
            $display("FAIL ignore_start_no_second_done: extra dones %0d ready %b required 0 1", extra, bus0.ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [20:0] got;
        int          dones = 0;
        issue0(16'hAAAA, 16'h5555, 1'b0);
        sb.delete();
        step();
        step();
        rst_n = 1'b0;
        #1;
        got = {bus0.ready, bus0.busy, bus0.done, bus0.sum, bus0.carry_out, bus0.overflow};
        n_checks++;
        if (got !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0})
            $display("FAIL reset_mid_run: got %h required %h", got, {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
        else n_pass++;
        step();
        rst_n = 1'b1;
        repeat (10) begin
            step();
            if (bus0.done) dones++;
        end
        n_checks++;
        if (dones !== 0 || bus0.ready !== 1'b1)
            $display("FAIL reset_no_done: dones %0d ready %b required 0 1", dones, bus0.ready);
        else n_pass++;
    endtask

    task automatic test_sub_en();
        logic [15:0] ta [2] = '{16'h0005, 16'h8000};
        logic [15:0] tb [2] = '{16'h0007, 16'h0001};
        res_t        te [2] = '{{16'h000C, 1'b0, 1'b0}, {16'h8001, 1'b0, 1'b0}};
        for (int i = 0; i < 2; i++) begin
            int   w = 0;
            res_t got;
            while (!bus1.ready && w < 20) begin step(); w++; end
            bus1.start = 1'b1;
            bus1.a     = ta[i];
            bus1.b     = tb[i];
            bus1.sub   = 1'b1;
            step();
            bus1.start = 1'b0;
            w = 0;
            do begin step(); w++; end while (!bus1.done && w < 40);
            got = {bus1.sum, bus1.carry_out, bus1.overflow};
            n_checks++;
            if (!bus1.done || got !== te[i])
                $display("FAIL sub_en0_%0d: done %b result %h required %h", i, bus1.done, got, te[i]);
            else n_pass++;
        end
    endtask

    task automatic test_full_digit();
        int   lat = 0;
        res_t got;
        bus2.start = 1'b1;
        bus2.a     = 16'hFFFF;
        bus2.b     = 16'hFFFF;
        bus2.sub   = 1'b0;
        step();
        bus2.start = 1'b0;
        do begin step(); lat++; end while (!bus2.done && lat < 40);
        got = {bus2.sum, bus2.carry_out, bus2.overflow};
        n_checks++;
        if (!bus2.done || got !== {16'hFFFE, 1'b1, 1'b0})
            $display("FAIL full_digit_result: done %b result %h required %h", bus2.done, got, {16'hFFFE, 1'b1, 1'b0});
        else n_pass++;
        n_checks++;
        if (lat !== 1) $display("FAIL full_digit_latency: got %0d required 1", lat);
        else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            int   lat;
            res_t got;
            res_t exp_sb;
            issue0(16'($urandom), 16'($urandom), 1'($urandom));
            wait_done0(lat);
            got    = {bus0.sum, bus0.carry_out, bus0.overflow};
            exp_sb = (sb.size() > 0) ? sb.pop_front() : '0;
            n_checks++;
            if (!bus0.done || lat !== 4 || got !== exp_sb)
                $display("FAIL random_%0d: done %b lat %0d result %h required done 1 lat 4 result %h",
                         i, bus0.done, lat, got, exp_sb);
            else n_pass++;
        end
    endtask

    initial begin
        bus0.start = 1'b0; bus0.sub = 1'b0; bus0.a = '0; bus0.b = '0;
        bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0;
        bus2.start = 1'b0; bus2.sub = 1'b0; bus2.a = '0; bus2.b = '0;
        test_reset();
        test_arith();
        test_hold_clear();
        test_ignore_start();
        test_reset_mid();
        test_sub_en();
        test_full_digit();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
